// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: type codes, framing states and the type-field accessor.
package noc_pkg;

   localparam int FLIT_W = 67;
   localparam int TYPE_W = 3;

   localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd0;
   localparam logic [TYPE_W-1:0] TYPE_HEAD = 3'd1;
   localparam logic [TYPE_W-1:0] TYPE_DATA = 3'd2;
   localparam logic [TYPE_W-1:0] TYPE_TAIL = 3'd3;

   typedef enum logic {IDLE, PKT} frame_state_e;

   function automatic logic [TYPE_W-1:0] flit_type(input logic [FLIT_W-1:0] flit);
      return flit[FLIT_W-1 -: TYPE_W];
   endfunction

endpackage

// File: rtl/mux_out_buffer_if.sv
// Flit channel around the output buffer: upstream side from the mux, downstream side to the link.
interface mux_out_buffer_if
   import noc_pkg::*;
#(
   parameter int DATA_W = FLIT_W,
   parameter int VCH_W  = 2
);
   logic [DATA_W-1:0] idata;
   logic              ivalid;
   logic [VCH_W-1:0]  ivch;
   logic              icredit;
   logic [DATA_W-1:0] odata;
   logic              ovalid;
   logic [VCH_W-1:0]  ovch;
   logic              ocredit;

   modport slave  (input  idata, ivalid, ivch, ocredit,
                   output icredit, odata, ovalid, ovch);
   modport master (output idata, ivalid, ivch, ocredit,
                   input  icredit, odata, ovalid, ovch);
endinterface

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port; caller guarantees no pop when empty.
module noc_sync_fifo
   import noc_pkg::*;
#(
   parameter  int WIDTH = FLIT_W + 2,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [PTR_W:0]   count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // NOTE: the storage array is deliberately not reset; validity is carried by the pointers and count.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;

endmodule

// File: rtl/mux_out_buffer.sv
// Output flit buffer behind the router 2:1 mux: credit-gated forwarding plus framing/VC checks.
module mux_out_buffer
   import noc_pkg::*;
#(
   parameter  int DATA_W  = FLIT_W,
   parameter  int VCH_W   = 2,
   parameter  int DEPTH   = 4,
   parameter  int CREDITS = 4,
   localparam int OCC_W   = $clog2(DEPTH) + 1,
   localparam int CRD_W   = $clog2(CREDITS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   mux_out_buffer_if.slave  bus,
   output logic [OCC_W-1:0] occupancy,
   output logic [3:0]       err
);

   localparam int ENTRY_W = DATA_W + VCH_W;
   localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

   logic               fifo_full, fifo_empty, push, pop;
   logic [ENTRY_W-1:0] head;
   logic [TYPE_W-1:0]  in_type;
   logic [CRD_W-1:0]   credit_q, credit_d;
   frame_state_e       state_q, state_d;
   logic [VCH_W-1:0]   pkt_vc_q, pkt_vc_d;
   logic [3:0]         err_q, err_d;
   logic [DATA_W-1:0]  odata_q;
   logic [VCH_W-1:0]   ovch_q;
   logic               ovalid_q, icredit_q;

   // Pop decision uses the pre-push FIFO state, so a push into an empty FIFO waits one cycle.
   assign pop     = !fifo_empty && (credit_q != '0);
   assign push    = bus.ivalid && (!fifo_full || pop);
   assign in_type = flit_type(bus.idata);

   noc_sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({bus.idata, bus.ivch}),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (occupancy)
   );

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      credit_d = credit_q;
      state_d  = state_q;
      pkt_vc_d = pkt_vc_q;
      err_d    = err_q;

      if (bus.ivalid && fifo_full && !pop) err_d[0] = 1'b1;

      case ({bus.ocredit, pop})
         2'b10: begin
            if (credit_q == CRD_MAX) err_d[3] = 1'b1;
            else                     credit_d = credit_q + 1'b1;
         end
         2'b01:   credit_d = credit_q - 1'b1;
         default: ;
      endcase

      if (push) begin
         case (state_q)
            IDLE: begin
               if (in_type == TYPE_HEAD) begin
                  state_d  = PKT;
                  pkt_vc_d = bus.ivch;
               end else begin
                  err_d[1] = 1'b1;
               end
            end
            PKT: begin
               if (in_type == TYPE_DATA || in_type == TYPE_TAIL) begin
                  if (bus.ivch != pkt_vc_q) err_d[2] = 1'b1;
                  if (in_type == TYPE_TAIL) state_d = IDLE;
               end else begin
                  err_d[1] = 1'b1;
                  if (in_type == TYPE_HEAD) pkt_vc_d = bus.ivch;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit_q  <= CRD_MAX;
         state_q   <= IDLE;
         pkt_vc_q  <= '0;
         err_q     <= '0;
         odata_q   <= '0;
         ovch_q    <= '0;
         ovalid_q  <= 1'b0;
         icredit_q <= 1'b0;
      end else begin
         credit_q  <= credit_d;
         state_q   <= state_d;
         pkt_vc_q  <= pkt_vc_d;
         err_q     <= err_d;
         ovalid_q  <= pop;
         icredit_q <= pop;
         if (pop) begin
            odata_q <= head[ENTRY_W-1 -: DATA_W];
            ovch_q  <= head[VCH_W-1:0];
         end
      end
   end

   assign bus.odata   = odata_q;
   assign bus.ovch    = ovch_q;
   assign bus.ovalid  = ovalid_q;
   assign bus.icredit = icredit_q;
   assign err         = err_q;

endmodule

// File: tb/tb_mux_out_buffer.sv
// Directed bench for mux_out_buffer: scoreboard of forwarded flits checked by a negedge monitor.
module tb_mux_out_buffer;
   import noc_pkg::*;

   localparam int DATA_W  = 67;
   localparam int VCH_W   = 2;
   localparam int DEPTH   = 4;
   localparam int CREDITS = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] occupancy;
   logic [3:0] err;

   mux_out_buffer_if #(.DATA_W(DATA_W), .VCH_W(VCH_W)) bus ();

   mux_out_buffer #(.DATA_W(DATA_W), .VCH_W(VCH_W), .DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .occupancy (occupancy),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;
   int n_icr    = 0;
   logic [DATA_W+VCH_W-1:0] sb [$];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every presented flit must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.icredit) n_icr++;
         if (bus.ovalid) begin
            n_out++;
            check("sb_has_entry", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) check("out_flit", {bus.odata, bus.ovch}, sb.pop_front());
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [2:0] t, input logic [63:0] p, input logic [1:0] vc, input bit fwd);
      bus.idata  = {t, p};
      bus.ivch   = vc;
      bus.ivalid = 1'b1;
      if (fwd) sb.push_back({t, p, vc});
      idle(1);
      bus.ivalid = 1'b0;
   endtask

   task automatic credit_pulses(input int n);
      bus.ocredit = 1'b1;
      idle(n);
      bus.ocredit = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      sb.delete();
      n_out = 0;
      n_icr = 0;
   endtask

   initial begin
      bus.idata   = '0;
      bus.ivalid  = 1'b0;
      bus.ivch    = '0;
      bus.ocredit = 1'b0;

      // Reset and idle
      idle(2);
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", {bus.ovalid, bus.icredit, occupancy, err, bus.odata, bus.ovch}, '0);
      end
      #1;

      // One packet on VC 1, four credits
      do_reset();
      send(TYPE_HEAD, 64'h1000, 2'd1, 1'b1);
      for (int i = 1; i <= 3; i++) send(TYPE_DATA, 64'h1000 + 64'(i), 2'd1, 1'b1);
      send(TYPE_TAIL, 64'h1004, 2'd1, 1'b1);
      check("pkt_out_before_last", n_out, 3);
      check("pkt_4th_out_next", bus.ovalid, 1);
      idle(2);
      check("pkt_out_4", n_out, 4);
      check("pkt_tail_held", occupancy, 1);
      credit_pulses(1);
      check("pkt_tail_not_yet", bus.ovalid, 0);
      idle(1);
      check("pkt_tail_released", bus.ovalid, 1);
      idle(2);
      check("pkt_out_5", n_out, 5);
      check("pkt_icredit_5", n_icr, 5);
      check("pkt_err", err, 0);
      check("pkt_empty", occupancy, 0);

      // Credit stall, overflow drop, ordered drain
      do_reset();
      for (int i = 0; i < 8; i++)
         send((i == 0) ? TYPE_HEAD : TYPE_DATA, 64'h3000 + 64'(i), 2'd2, 1'b1);
      check("stall_out_4", n_out, 4);
      check("stall_full", occupancy, 4);
      check("stall_no_err", err, 0);
      send(TYPE_TAIL, 64'h3008, 2'd2, 1'b0);
      check("ovf_err", err, 4'b0001);
      check("ovf_still_full", occupancy, 4);
      idle(3);
      check("stall_hold_out", n_out, 4);
      credit_pulses(4);
      idle(3);
      check("drain_out_8", n_out, 8);
      check("drain_empty", occupancy, 0);
      check("drain_sb_empty", sb.size(), 0);
      check("drain_err_sticky", err, 4'b0001);

      // Framing and VC errors, simultaneous credit return and pop
      do_reset();
      send(TYPE_DATA, 64'h5000, 2'd0, 1'b1);
      check("frm_data_idle", err, 4'b0010);
      send(TYPE_HEAD, 64'h5001, 2'd0, 1'b1);
      send(TYPE_DATA, 64'h5002, 2'd2, 1'b1);
      check("frm_vc_change", err, 4'b0110);
      idle(2);
      check("frm_forwarded", n_out, 3);
      send(TYPE_TAIL, 64'h5003, 2'd0, 1'b1);
      credit_pulses(1);
      check("frm_pop_with_credit", bus.ovalid, 1);
      send(TYPE_HEAD, 64'h5004, 2'd0, 1'b1);
      idle(1);
      check("frm_credit_kept", bus.ovalid, 1);
      send(TYPE_TAIL, 64'h5005, 2'd0, 1'b1);
      idle(3);
      check("frm_credit_exhausted", occupancy, 1);
      check("frm_out_5", n_out, 5);
      check("frm_err_final", err, 4'b0110);

      // Reset mid-packet
      do_reset();
      credit_pulses(1);
      check("sat_err3", err, 4'b1000);
      send(TYPE_HEAD, 64'h6000, 2'd3, 1'b1);
      for (int i = 1; i < 7; i++) send(TYPE_DATA, 64'h6000 + 64'(i), 2'd3, 1'b1);
      check("mid_occ_3", occupancy, 3);
      rst = 1'b1;
      idle(1);
      check("rst_outputs", {occupancy, err, bus.ovalid, bus.icredit}, '0);
      rst = 1'b0;
      sb.delete();
      n_out = 0;
      n_icr = 0;
      idle(3);
      check("rst_no_out", n_out, 0);
      check("rst_no_icredit", n_icr, 0);
      credit_pulses(1);
      check("rst_credit_full", err, 4'b1000);
      send(TYPE_DATA, 64'h6100, 2'd1, 1'b1);
      check("rst_fsm_idle", err, 4'b1010);
      idle(2);
      check("rst_data_out", n_out, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
